serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: computes d = a - b - bin, one bit per clock,
//  LSB first, with a single full-subtractor cell and a borrow register.

---
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial N-bit subtractor: d = a - b - bin, computed one bit per clock,
//   LSB first, with a single full-subtractor cell and a borrow register.
//   Operands are captured on an accepted start. The result appears together
//   with a one-cycle done pulse, so one operation takes N+2 cycles.
//
// Ports
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset (overrides start)
//   start  in   1  request, sampled only while idle
//   a      in   N  minuend, captured on accepted start
//   b      in   N  subtrahend, captured on accepted start
//   bin    in   1  borrow-in, captured on accepted start
//   busy   out  1  high while an operation is in RUN or DONE
//   done   out  1  one-cycle pulse; d/bout/ovf are valid in this cycle
//   d      out  N  difference, held until the next operation completes
//   bout   out  1  borrow out of bit N-1 (unsigned a < b + bin)
//   ovf    out  1  signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    // Holds the N-1 low result bits; the MSB is taken straight from the cell
    // on the final RUN edge.
    logic [N-2:0]    r_sh;
    logic            br;

    logic            diff_c;
    logic            br_next_c;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        diff_c    = a_sh[0] ^ b_sh[0] ^ br;
        br_next_c = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            br    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    // Shift the new difference bit in at the top.
                    r_sh <= (N-1)'({diff_c, r_sh} >> 1);
                    br   <= br_next_c;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        // br is the borrow into the MSB at this point.
                        d     <= {diff_c, r_sh};
                        bout  <= br_next_c;
                        ovf   <= br ^ br_next_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor. Drivers push the expected result
//   and completion cycle into a queue when a start is issued; monitors pop and
//   compare whenever done is seen. An N=8 instance runs directed vectors, an
//   N=4 instance runs all 512 operand combinations back to back.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;

    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, d8;
    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, d4;

    exp_t q8[$];
    exp_t q4[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic prev8 = 1'b0;
    logic prev4 = 1'b0;

    serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // N=8 monitor.
    always @(negedge clk) begin
        if (done8) begin
            chk("done8_width", int'(prev8), 0);
            if (q8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("d8", int'(d8), int'(e.d));
                chk("bout8", int'(bout8), int'(e.bout));
                chk("ovf8", int'(ovf8), int'(e.ovf));
                chk("done8_cycle", cyc, e.cyc);
            end
        end
        prev8 = done8;
    end

    // N=4 monitor.
    always @(negedge clk) begin
        if (done4) begin
            chk("done4_width", int'(prev4), 0);
            if (q4.size() == 0) begin
                chk("done4_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("d4", int'(d4), int'(e.d));
                chk("bout4", int'(bout4), int'(e.bout));
                chk("ovf4", int'(ovf4), int'(e.ovf));
                chk("done4_cycle", cyc, e.cyc);
            end
        end
        prev4 = done4;
    end

    // Issue one N=8 op with hand-computed expectation and let it complete.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input logic eo);
        exp_t e;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        e.d = ed; e.bout = eb; e.ovf = eo; e.cyc = cyc + 9;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        repeat (10) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_done", int'(done8), 0);
        chk("rst_d", int'(d8), 0);
        chk("rst_bout", int'(bout8), 0);
        chk("rst_ovf", int'(ovf8), 0);
        rst = 1'b0;

        // Directed arithmetic vectors.
        op8(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
        op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Start requests during RUN and DONE are ignored.
        begin
            exp_t e;
            @(negedge clk);
            a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
            e.d = 8'h0F; e.bout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 9;
            q8.push_back(e);
            @(negedge clk);
            start8 = 1'b0;
            chk("busy_run", int'(busy8), 1);
            repeat (2) @(negedge clk);
            a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            repeat (5) @(negedge clk);
            chk("done_at_k_plus_n", int'(done8), 1);
            chk("busy_in_done", int'(busy8), 1);
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            chk("busy_after_done", int'(busy8), 0);
            chk("done_after_done", int'(done8), 0);
            repeat (12) @(negedge clk);
            chk("d_held", int'(d8), 8'h0F);
            chk("q8_ignored_starts", q8.size(), 0);
        end

        // Reset in the middle of RUN aborts the op.
        @(negedge clk);
        a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        chk("abort_d", int'(d8), 0);
        repeat (12) @(negedge clk);
        op8(8'h03, 8'h02, 1'b0, 8'h01, 1'b0, 1'b0);

        // Exhaustive N=4 at full N+2 throughput against an arithmetic model.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp_t e;
                    int diff, sa, sb, sd;
                    diff = ai - bi - ci;
                    sa = (ai >= 8) ? ai - 16 : ai;
                    sb = (bi >= 8) ? bi - 16 : bi;
                    sd = sa - sb - ci;
                    @(negedge clk);
                    chk("busy4_at_issue", int'(busy4), 0);
                    a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); start4 = 1'b1;
                    e.d = 8'(diff & 15);
                    e.bout = (diff < 0);
                    e.ovf = (sd > 7) || (sd < -8);
                    e.cyc = cyc + 5;
                    q4.push_back(e);
                    @(negedge clk);
                    start4 = 1'b0;
                    repeat (4) @(negedge clk);
                end
            end
        end
        repeat (8) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_final", q8.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
